// File: rtl/dm_lane_pkg.sv
// Shared types and constants for the lane sequencer: FSM state encoding,
// memory word size and the parameter defaults used by the interface and top.
package dm_lane_pkg;

  localparam int WORD_BYTES      = 4;
  localparam int DEF_NUM_LANES   = 4;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_RD_LAT      = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Lane index width, kept at least 1 bit so a single-lane build still has a real index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dm_lane_seq_if.sv
// Core-side request/response bus plus the single-port memory bus of the lane sequencer.
interface dm_lane_seq_if
  import dm_lane_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only while idle, and request fields are ignored otherwise.
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_we;
  logic [ADDR_W-1:0]           req_addr;
  logic [NUM_LANES-1:0]        req_mask;
  logic [NUM_LANES*DATA_W-1:0] req_wd;
  logic                        resp_valid;
  logic [NUM_LANES*DATA_W-1:0] resp_rd;
  logic                        busy;
  logic                        mem_en;
  logic                        mem_we;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_wd;
  logic [DATA_W-1:0]           mem_rd;

  modport slave (
    input  req_valid, req_we, req_addr, req_mask, req_wd, mem_rd,
    output req_ready, resp_valid, resp_rd, busy, mem_en, mem_we, mem_addr, mem_wd
  );

  modport master (
    output req_valid, req_we, req_addr, req_mask, req_wd, mem_rd,
    input  req_ready, resp_valid, resp_rd, busy, mem_en, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/dm_lane_seq_lane_pick.sv
// Finds the lowest enabled lane at or above a start index; o_last is set when
// no such lane exists, i.e. the lane before i_from was the final one.
module lane_pick #(
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_LANES-1:0] i_mask,
  input  logic [IDX_W:0]       i_from,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_last
);

  always_comb begin
    o_idx  = '0;
    o_last = 1'b1;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (i_mask[i] && (i >= int'(i_from))) begin
        o_idx  = IDX_W'(i);
        o_last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/dm_lane_seq.sv
// Masked multi-lane load/store sequencer: serialises enabled lanes onto a
// single-port memory and gathers load data back into a packed response.
module dm_lane_seq
  import dm_lane_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              rst,
  dm_lane_seq_if.slave      bus,
  output state_e            o_dbg_state
);

  localparam int IDX_W = idx_w(NUM_LANES);
  localparam int CNT_W = 3;

  state_e                      r_state;
  logic                        r_we;
  logic [ADDR_W-1:0]           r_addr;
  logic [NUM_LANES-1:0]        r_mask;
  logic [NUM_LANES*DATA_W-1:0] r_wd;
  logic [IDX_W-1:0]            r_idx;
  logic [CNT_W-1:0]            r_dcnt;
  logic [NUM_LANES*DATA_W-1:0] r_resp_rd;
  logic [RD_LAT-1:0]           r_pv;
  logic [IDX_W-1:0]            r_pidx [RD_LAT];

  logic             w_accept;
  logic             w_issue;
  logic [IDX_W-1:0] w_first_idx;
  logic             w_first_none;
  logic [IDX_W:0]   w_next_from;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_issue_last;

  assign w_accept    = bus.req_valid && (r_state == ST_IDLE);
  assign w_issue     = (r_state == ST_ISSUE);
  assign w_next_from = {1'b0, r_idx} + {{IDX_W{1'b0}}, 1'b1};

  lane_pick #(.NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_pick_first (
    .i_mask (bus.req_mask),
    .i_from ('0),
    .o_idx  (w_first_idx),
    .o_last (w_first_none)
  );

  lane_pick #(.NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) u_pick_next (
    .i_mask (r_mask),
    .i_from (w_next_from),
    .o_idx  (w_next_idx),
    .o_last (w_issue_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_mask  <= '0;
      r_wd    <= '0;
      r_idx   <= '0;
      r_dcnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_we    <= bus.req_we;
          r_addr  <= bus.req_addr;
          r_mask  <= bus.req_mask;
          r_wd    <= bus.req_wd;
          r_idx   <= w_first_idx;
          r_state <= w_first_none ? ST_RESP : ST_ISSUE;
        end
        ST_ISSUE: begin
          r_idx <= w_next_idx;
          if (w_issue_last) begin
            r_state <= r_we ? ST_RESP : ST_DRAIN;
            r_dcnt  <= CNT_W'(RD_LAT - 1);
          end
        end
        ST_DRAIN: begin
          if (r_dcnt == '0) r_state <= ST_RESP;
          else              r_dcnt  <= r_dcnt - 1'b1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Each load issue tags its lane; the tag surfaces exactly when that lane's data arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv      <= '0;
      r_resp_rd <= '0;
    end else begin
      r_pv[0]   <= w_issue && !r_we;
      r_pidx[0] <= r_idx;
      for (int j = 1; j < RD_LAT; j++) begin
        r_pv[j]   <= r_pv[j-1];
        r_pidx[j] <= r_pidx[j-1];
      end
      if (w_accept)
        r_resp_rd <= '0;
      else if (r_pv[RD_LAT-1])
        r_resp_rd[r_pidx[RD_LAT-1]*DATA_W +: DATA_W] <= bus.mem_rd;
    end
  end

  assign bus.req_ready  = (r_state == ST_IDLE);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.resp_valid = (r_state == ST_RESP);
  assign bus.resp_rd    = r_resp_rd;
  assign bus.mem_en     = w_issue;
  assign bus.mem_we     = w_issue && r_we;
  assign bus.mem_addr   = w_issue ? r_addr + ADDR_W'(WORD_BYTES * int'(r_idx)) : '0;
  assign bus.mem_wd     = (w_issue && r_we) ? r_wd[r_idx*DATA_W +: DATA_W] : '0;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_dm_lane_seq.sv
// Bench for dm_lane_seq: two instances (read latency 1 and 3) share one request
// stream; each has its own latency memory model and is checked against a lane-level model.
module tb_dm_lane_seq;
  import dm_lane_pkg::*;

  localparam int NL = 4;
  localparam int DW = 32;
  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         req_valid = 1'b0;
  logic         req_we    = 1'b0;
  logic [31:0]  req_addr  = '0;
  logic [3:0]   req_mask  = '0;
  logic [127:0] req_wd    = '0;

  dm_lane_seq_if #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW)) if0 ();
  dm_lane_seq_if #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW)) if1 ();
  state_e st0, st1;

  dm_lane_seq #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0), .o_dbg_state(st0));
  dm_lane_seq #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1), .o_dbg_state(st1));

  assign if0.req_valid = req_valid;  assign if1.req_valid = req_valid;
  assign if0.req_we    = req_we;     assign if1.req_we    = req_we;
  assign if0.req_addr  = req_addr;   assign if1.req_addr  = req_addr;
  assign if0.req_mask  = req_mask;   assign if1.req_mask  = req_mask;
  assign if0.req_wd    = req_wd;     assign if1.req_wd    = req_wd;

  logic         mem_en_a[2], mem_we_a[2], resp_valid_a[2], ready_a[2], busy_a[2];
  logic [31:0]  mem_addr_a[2], mem_wd_a[2];
  logic [127:0] resp_rd_a[2];
  assign mem_en_a[0] = if0.mem_en;         assign mem_en_a[1] = if1.mem_en;
  assign mem_we_a[0] = if0.mem_we;         assign mem_we_a[1] = if1.mem_we;
  assign mem_addr_a[0] = if0.mem_addr;     assign mem_addr_a[1] = if1.mem_addr;
  assign mem_wd_a[0] = if0.mem_wd;         assign mem_wd_a[1] = if1.mem_wd;
  assign resp_valid_a[0] = if0.resp_valid; assign resp_valid_a[1] = if1.resp_valid;
  assign resp_rd_a[0] = if0.resp_rd;       assign resp_rd_a[1] = if1.resp_rd;
  assign ready_a[0] = if0.req_ready;       assign ready_a[1] = if1.req_ready;
  assign busy_a[0] = if0.busy;             assign busy_a[1] = if1.busy;

  // ---------------- memory model ----------------
  function automatic logic [31:0] fdata(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  logic [31:0] rdp [2][3];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      rdp[d][0] <= (mem_en_a[d] && !mem_we_a[d]) ? fdata(mem_addr_a[d]) : $urandom;
      rdp[d][1] <= rdp[d][0];
      rdp[d][2] <= rdp[d][1];
    end
  end
  assign if0.mem_rd = rdp[0][0];
  assign if1.mem_rd = rdp[1][2];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } acc_t;

  acc_t         acc_q0[$], acc_q1[$], exp_q[$];
  int           resp_cnt[2];
  int           resp_cyc[2];
  logic [127:0] resp_dat[2];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    acc_t a_rec;
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if ((busy_a[d] !== !ready_a[d]) || (!mem_en_a[d] && mem_we_a[d] !== 1'b0)) begin
          n_fail++;
          $display("FAIL bus_invariant dut%0d cyc %0d: busy=%b ready=%b en=%b we=%b expected busy=!ready, we=0 when en=0",
                   d, cyc, busy_a[d], ready_a[d], mem_en_a[d], mem_we_a[d]);
        end
        if (mem_en_a[d]) begin
          a_rec = {32'(cyc), mem_we_a[d], mem_addr_a[d], mem_wd_a[d]};
          if (d == 0) acc_q0.push_back(a_rec);
          else        acc_q1.push_back(a_rec);
        end
        if (resp_valid_a[d]) begin
          resp_cnt[d]++;
          resp_cyc[d] = cyc;
          resp_dat[d] = resp_rd_a[d];
        end
      end
    end
  end

  // Model: one access per enabled lane in ascending order from T+1, then response timing.
  task automatic check_txn(input int d, input logic we, input logic [31:0] addr,
                           input logic [3:0] mask, input logic [127:0] wd, input int t,
                           input int tbl_n, input int tbl_off);
    int           lat;
    int           n;
    int           off;
    int           nobs;
    logic [127:0] exp_rd;
    logic [31:0]  la;
    acc_t         o;
    lat    = (d == 0) ? 1 : 3;
    n      = 0;
    exp_rd = '0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        la = addr + 32'(4 * i);
        exp_q.push_back({32'(t + 1 + n), we, la, we ? wd[i*32 +: 32] : 32'h0});
        if (!we) exp_rd[i*32 +: 32] = fdata(la);
        n++;
      end
    end
    off  = (n == 0) ? 1 : (we ? n + 1 : n + lat + 1);
    nobs = (d == 0) ? acc_q0.size() : acc_q1.size();
    chk($sformatf("dut%0d access_count", d), 128'(nobs), 128'(n));
    if (tbl_n >= 0) chk($sformatf("dut%0d table_access_count", d), 128'(nobs), 128'(tbl_n));
    for (int k = 0; k < n && k < nobs; k++) begin
      o = (d == 0) ? acc_q0[k] : acc_q1[k];
      chk($sformatf("dut%0d access%0d {cyc,we,addr,wd}", d, k), 128'(o), 128'(exp_q[k]));
    end
    chk($sformatf("dut%0d resp_count", d), 128'(resp_cnt[d]), 128'(1));
    chk($sformatf("dut%0d resp_latency", d), 128'(resp_cyc[d] - t), 128'(off));
    if (tbl_off >= 0) chk($sformatf("dut%0d table_resp_latency", d), 128'(resp_cyc[d] - t), 128'(tbl_off));
    chk($sformatf("dut%0d resp_rd", d), resp_dat[d], exp_rd);
    chk($sformatf("dut%0d resp_rd_hold", d), resp_rd_a[d], exp_rd);
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [127:0] wd, output int t);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(ready_a[0] && ready_a[1]) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("idle_before_request", 128'(guard < 50), 128'(1));
    acc_q0.delete();
    acc_q1.delete();
    resp_cnt[0] = 0;
    resp_cnt[1] = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_mask = mask; req_wd = wd;
    t = cyc;
    @(negedge clk);
    guard = 0;
    while ((resp_cnt[0] == 0 || resp_cnt[1] == 0) && guard < 40) begin
      if (busy_a[0] && busy_a[1]) begin
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_mask  = 4'($urandom_range(0, 15));
        req_wd    = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    chk("resp_within_budget", 128'(guard < 40), 128'(1));
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    int          n;
    int          off0;
    int          off1;
  } vec_t;

  vec_t         vt[8];
  int           t;
  logic         r_we;
  logic [31:0]  r_addr;
  logic [3:0]   r_mask;
  logic [127:0] r_wd;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b0, 32'h0000_0100, 4'b1111, 4, 6, 8};
    vt[1] = '{1'b1, 32'h0000_0040, 4'b0101, 2, 3, 3};
    vt[2] = '{1'b0, 32'h0000_0080, 4'b0000, 0, 1, 1};
    vt[3] = '{1'b0, 32'hFFFF_FFF8, 4'b1111, 4, 6, 8};
    vt[4] = '{1'b0, 32'h0000_0200, 4'b1010, 2, 4, 6};
    vt[5] = '{1'b1, 32'hFFFF_FFF8, 4'b1111, 4, 5, 5};
    vt[6] = '{1'b0, 32'h0000_0010, 4'b1000, 1, 3, 5};
    vt[7] = '{1'b1, 32'h0000_0000, 4'b0000, 0, 1, 1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d reset {ready,busy,resp_valid,en,we}", d),
          128'({ready_a[d], busy_a[d], resp_valid_a[d], mem_en_a[d], mem_we_a[d]}), 128'(5'b10000));
      chk($sformatf("dut%0d reset resp_rd", d), resp_rd_a[d], '0);
      chk($sformatf("dut%0d reset {mem_addr,mem_wd}", d), 128'({mem_addr_a[d], mem_wd_a[d]}), '0);
    end
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      r_wd = {$urandom, $urandom, $urandom, $urandom};
      run_txn(vt[i].we, vt[i].addr, vt[i].mask, r_wd, t);
      check_txn(0, vt[i].we, vt[i].addr, vt[i].mask, r_wd, t, vt[i].n, vt[i].off0);
      check_txn(1, vt[i].we, vt[i].addr, vt[i].mask, r_wd, t, vt[i].n, vt[i].off1);
    end

    for (int i = 0; i < 30; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      r_mask = 4'($urandom_range(0, 15));
      r_wd   = {$urandom, $urandom, $urandom, $urandom};
      run_txn(r_we, r_addr, r_mask, r_wd, t);
      check_txn(0, r_we, r_addr, r_mask, r_wd, t, -1, -1);
      check_txn(1, r_we, r_addr, r_mask, r_wd, t, -1, -1);
    end

    // Reset two cycles into a 4-lane load; late read data must not land anywhere.
    @(negedge clk);
    resp_cnt[0] = 0;
    resp_cnt[1] = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_mask = 4'b1111; req_wd = '0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d midreset {ready,busy,resp_valid,en,we}", d),
          128'({ready_a[d], busy_a[d], resp_valid_a[d], mem_en_a[d], mem_we_a[d]}), 128'(5'b10000));
      chk($sformatf("dut%0d midreset {mem_addr,mem_wd}", d), 128'({mem_addr_a[d], mem_wd_a[d]}), '0);
    end
    chk("dut0 midreset state", 128'(st0), 128'(ST_IDLE));
    chk("dut1 midreset state", 128'(st1), 128'(ST_IDLE));
    repeat (8) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d midreset no_resp", d), 128'(resp_cnt[d]), 128'(0));
      chk($sformatf("dut%0d midreset resp_rd", d), resp_rd_a[d], '0);
    end
    r_wd = {$urandom, $urandom, $urandom, $urandom};
    run_txn(1'b0, 32'h400, 4'b1111, r_wd, t);
    check_txn(0, 1'b0, 32'h400, 4'b1111, r_wd, t, 4, 6);
    check_txn(1, 1'b0, 32'h400, 4'b1111, r_wd, t, 4, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
